mio_responder: RTL
==================

# mio_responder

Memory/I-O bus responder that answers the multi-cycle CPU's memory requests. Sits between the CPU datapath's memory port (address, write data, read data, ready) and the devices behind it: a synchronous block RAM, a 32-bit GPIO register pair (LEDs and switches), and an optional down-counter used by the application for frame timing. It decodes the address, sequences each access through a small FSM, returns read data, and pulses `MIO_ready` when the access completes.

## Interface
- `RAM_AW`, 12, RAM word-address width (RAM holds 2^RAM_AW 32-bit words)
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `mem_r`  in  1  CPU read request, held until `MIO_ready` seen
- `mem_w`  in  1  CPU write request, held until `MIO_ready` seen
- `M_addr`  in  32  CPU byte address
- `data_out`  in  32  CPU write data
- `data2CPU`  out  32  read data to CPU, valid while `MIO_ready`=1
- `MIO_ready`  out  1  one-cycle completion pulse
- `ram_addr`  out  RAM_AW  RAM word address
- `ram_din`  out  32  RAM write data
- `ram_we`  out  1  RAM write enable
- `ram_dout`  in  32  RAM read data, 1-cycle latency after `ram_addr`
- `sw`  in  32  switch inputs
- `led`  out  32  LED register
- `counter_out`  out  32  current counter value
- `counter_zero`  out  1  one-cycle pulse when counter decrements 1→0

## Operation
- Address map (decode on `M_addr[31:28]`): 0x0 RAM (word index `M_addr[RAM_AW+1:2]`); 0xE counter; 0xF GPIO (write → `led`, read → `sw`). All others unmapped: read returns 0, write ignored, still completes.
- `M_addr[1:0]` ignored; accesses are whole words.
- FSM states: IDLE → ACCESS → RESP → IDLE.
  - IDLE: if `mem_r|mem_w`, latch address, write data, and direction; go to ACCESS. Both asserted → treated as write.
  - ACCESS: drive `ram_addr`; for RAM writes `ram_we`=1 for this cycle only; for GPIO/counter writes, update register at end of cycle. Go to RESP.
  - RESP: `MIO_ready`=1, `data2CPU` = selected source (RAM `ram_dout`, `sw` sampled this cycle, counter value this cycle, or 0). Writes return 0. Go to IDLE.
- The CPU must deassert its request in the cycle after `MIO_ready`. A request still high in IDLE is taken as a new access.
- Counter: decrements by 1 each cycle while nonzero; holds at 0. A write loads `data_out` and wins over a same-cycle decrement. `counter_zero` pulses in the cycle the value becomes 0 by decrement, not by a load of 0.
- Reset (including mid-transaction): state IDLE, `MIO_ready`=0, `data2CPU`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `led`=0, counter=0, `counter_zero`=0. An in-flight access is dropped with no write.

## Timing
- Request seen high in IDLE at edge N → ACCESS during cycle N+1 → `MIO_ready` high during cycle N+2. The fixed latency is 2 cycles for every region and direction.
- Back-to-back throughput: one access per 3 cycles.
- All outputs are registered except `data2CPU`, which is muxed from registered sources plus `ram_dout`.
- `ram_we` never asserts outside ACCESS.

## Configuration
- `MIO_COUNTER_EN` defined: counter, `counter_out`, and `counter_zero` are functional as above.
- Not defined: no counter logic. Region 0xE behaves as unmapped. `counter_out`=0 and `counter_zero`=0 constantly.

## Structure
- Package `mio_pkg`: region codes (RAM 4'h0, CNT 4'hE, GPIO 4'hF), FSM state enum (IDLE/ACCESS/RESP), and the 2-cycle latency constant.
- One sub-module `mio_counter` (load, value, decrement, zero pulse), instantiated only under `MIO_COUNTER_EN`.

## Test plan
- RAM write 0xDEADBEEF to 0x0000_0010, then read the same address → `ram_we` high 1 cycle with `ram_addr`=4; read returns 0xDEADBEEF; each `MIO_ready` exactly 2 cycles after the request.
- GPIO write 0x0000_00A5 to 0xF000_0000 → `led`=0x000000A5; with `sw`=0x12345678, a read of 0xF000_0000 returns 0x12345678.
- Counter write 3 to 0xE000_0000 → values 3,2,1,0 on consecutive cycles; `counter_zero` pulses once on reaching 0; a later read returns 0.
- Unmapped read at 0x5000_0000 → `data2CPU`=0 with `MIO_ready` after 2 cycles; a write to the same address changes no state.
- `reset` asserted in ACCESS of a RAM write → no `ram_we`; all outputs at reset values next cycle; a following request completes normally.
- `mem_r` and `mem_w` both high at a RAM address → performed as a write; without `MIO_COUNTER_EN`, a write to 0xE000_0000 leaves `counter_out`=0.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared definitions for the memory/I-O responder: region codes, FSM states
// and the fixed request-to-ready latency.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [3:0] RGN_RAM  = 4'h0;
  localparam logic [3:0] RGN_CNT  = 4'hE;
  localparam logic [3:0] RGN_GPIO = 4'hF;

  localparam int LATENCY = 2;

endpackage

// File: rtl/mio_counter.sv
// Application frame-timing down-counter: loadable, decrements to zero and holds,
// pulses zero only when it reaches 0 by decrementing.
module mio_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] value,
  output logic        zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
      zero  <= 1'b0;
    end else if (load) begin
      // a load wins over the decrement and never raises the zero pulse
      value <= load_val;
      zero  <= 1'b0;
    end else if (value != 32'd0) begin
      value <= value - 32'd1;
      zero  <= (value == 32'd1);
    end else begin
      zero  <= 1'b0;
    end
  end

endmodule

// File: rtl/mio_responder.sv
// Memory/I-O bus responder for the multi-cycle CPU: RAM, GPIO and optional counter.
// Define MIO_COUNTER_EN to build the frame-timing counter at region 0xE.
//
// state  | meaning
// IDLE   | waiting for mem_r/mem_w, latches the request
// ACCESS | RAM address/write enable driven, register writes committed
// RESP   | MIO_ready high, data2CPU carries the read result
module mio_responder
  import mio_pkg::*;
#(
  parameter int RAM_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [31:0]       M_addr,
  input  logic [31:0]       data_out,
  output logic [31:0]       data2CPU,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [31:0]       sw,
  output logic [31:0]       led,
  output logic [31:0]       counter_out,
  output logic              counter_zero
);

  state_t     state, state_nxt;
  logic [3:0] region_q;
  logic       wr_q;
  logic       ram_we_q;
  logic       accept;
  logic       led_wr;
  logic       cnt_load;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{M_addr[27:RAM_AW+2], M_addr[1:0]};
  assign accept = (state == IDLE) && (mem_r || mem_w);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_r || mem_w) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MIO_COUNTER_EN
  logic [31:0] cnt_value;

  mio_counter u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (ram_din),
    .value    (cnt_value),
    .zero     (counter_zero)
  );

  assign counter_out = cnt_value;
`else
  assign counter_out  = '0;
  assign counter_zero = 1'b0;
`endif

  always_comb begin
    data2CPU = '0;
    led_wr   = (state == ACCESS) && wr_q && (region_q == RGN_GPIO);
    cnt_load = (state == ACCESS) && wr_q && (region_q == RGN_CNT);
    if (state == RESP && !wr_q) begin
      case (region_q)
        RGN_RAM:  data2CPU = ram_dout;
        RGN_GPIO: data2CPU = sw;
`ifdef MIO_COUNTER_EN
        RGN_CNT:  data2CPU = cnt_value;
`endif
        default:  data2CPU = '0;
      endcase
    end
  end

  // ram_din doubles as the latched write data for every region
  always_ff @(posedge clk) begin
    if (reset) begin
      region_q  <= '0;
      wr_q      <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we_q  <= 1'b0;
      MIO_ready <= 1'b0;
      led       <= '0;
    end else begin
      MIO_ready <= (state == ACCESS);
      ram_we_q  <= accept && mem_w && (M_addr[31:28] == RGN_RAM);
      if (accept) begin
        region_q <= M_addr[31:28];
        wr_q     <= mem_w;
        ram_addr <= M_addr[RAM_AW+1:2];
        ram_din  <= data_out;
      end
      if (led_wr) led <= ram_din;
    end
  end

  // the RAM samples ram_we on the same edge that applies reset, so gate it to drop the write
  assign ram_we = ram_we_q && !reset;

endmodule
